// File: rtl/img_window_filter_if.sv
// Pixel stream bundle for img_window_filter: input beats, filtered output stream and status.
interface img_window_filter_if #(
   parameter int BIT_LENGTH    = 5,
   parameter int PIX_PER_CYCLE = 3
);
   logic                                mode;
   logic                                in_valid;
   logic                                in_ready;
   logic [PIX_PER_CYCLE*BIT_LENGTH-1:0] pixel_in;
   logic                                out_valid;
   logic                                out_ready;
   logic [BIT_LENGTH-1:0]               pixel_out;
   logic                                out_last;
   logic                                busy;

   modport master (
      output mode, in_valid, pixel_in, out_ready,
      input  in_ready, out_valid, pixel_out, out_last, busy
   );

   modport slave (
      input  mode, in_valid, pixel_in, out_ready,
      output in_ready, out_valid, pixel_out, out_last, busy
   );
endinterface

// File: rtl/img_window_filter.sv
// 3x3 median/Gaussian window filter over a buffered IMG_DIM x IMG_DIM frame.
// IMG_WINDOW_REPLICATE_EN: filter the full frame with edge-clamped taps instead of the interior only.
//
// state  | meaning
// LOAD   | accepting input beats into frame storage
// FILTER | streaming filtered pixels out, input stalled
module img_window_filter #(
   parameter int IMG_DIM       = 20,
   parameter int BIT_LENGTH    = 5,
   parameter int PIX_PER_CYCLE = 3
) (
   input logic               clk,
   input logic               reset,
   img_window_filter_if.slave bus
);
   localparam int NPIX = IMG_DIM * IMG_DIM;
   localparam int AW   = $clog2(NPIX);
   localparam int CW   = $clog2(NPIX + 1);
   localparam int RW   = $clog2(IMG_DIM);
`ifdef IMG_WINDOW_REPLICATE_EN
   localparam int LO = 0;
   localparam int HI = IMG_DIM - 1;
`else
   localparam int LO = 1;
   localparam int HI = IMG_DIM - 2;
`endif

   typedef enum logic {LOAD, FILTER} state_t;
   state_t state, next_state;

   logic [BIT_LENGTH-1:0] mem [NPIX];
   logic [BIT_LENGTH-1:0] win [9];
   logic [BIT_LENGTH-1:0] filt;
   logic [CW-1:0]         load_count;
   logic [RW-1:0]         row_q, col_q;
   logic                  mode_q, gen_done;
   logic                  out_valid_q, out_last_q;
   logic [BIT_LENGTH-1:0] pixel_out_q;
   logic                  in_ready_c, busy_c;
   logic                  accept, load_last, at_last_pos, advance, xfer;
   int                    take_n;

   assign bus.in_ready  = in_ready_c;
   assign bus.busy      = busy_c;
   assign bus.out_valid = out_valid_q;
   assign bus.pixel_out = pixel_out_q;
   assign bus.out_last  = out_last_q;

   always_comb begin
      take_n = NPIX - int'(load_count);
      if (take_n > PIX_PER_CYCLE) take_n = PIX_PER_CYCLE;
      accept      = (state == LOAD) && bus.in_valid;
      load_last   = accept && (int'(load_count) + take_n >= NPIX);
      xfer        = out_valid_q && bus.out_ready;
      at_last_pos = (row_q == RW'(HI)) && (col_q == RW'(HI));
      advance     = (state == FILTER) && !gen_done && (!out_valid_q || bus.out_ready);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= LOAD;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready_c = 1'b0;
      busy_c     = 1'b0;
      case (state)
         LOAD: begin
            in_ready_c = 1'b1;
            if (load_last) next_state = FILTER;
         end
         FILTER: begin
            busy_c = 1'b1;
            if (xfer && out_last_q) next_state = LOAD;
         end
         default: next_state = LOAD;
      endcase
   end

   // Frame storage is deliberately left out of reset; a new frame always overwrites it fully.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < PIX_PER_CYCLE; k++) begin
            if (k < take_n) mem[AW'(int'(load_count) + k)] <= bus.pixel_in[k*BIT_LENGTH +: BIT_LENGTH];
         end
      end
   end

   always_comb begin
      int rr, cc;
      rr  = 0;
      cc  = 0;
      win = '{default: '0};
      for (int dr = 0; dr < 3; dr++) begin
         for (int dc = 0; dc < 3; dc++) begin
            rr = int'(row_q) + dr - 1;
            cc = int'(col_q) + dc - 1;
`ifdef IMG_WINDOW_REPLICATE_EN
            if (rr < 0) rr = 0; else if (rr > IMG_DIM - 1) rr = IMG_DIM - 1;
            if (cc < 0) cc = 0; else if (cc > IMG_DIM - 1) cc = IMG_DIM - 1;
`endif
            win[dr*3 + dc] = mem[AW'(rr * IMG_DIM + cc)];
         end
      end
   end

   // Median: the element with at most 4 smaller and at least 5 smaller-or-equal entries.
   always_comb begin
      logic [BIT_LENGTH+3:0] sum;
      logic [BIT_LENGTH-1:0] med;
      int                    lt, le, sh;
      sum = '0;
      med = '0;
      lt  = 0;
      le  = 0;
      sh  = 0;
      for (int i = 0; i < 9; i++) begin
         sh  = ((i / 3 == 1) ? 1 : 0) + ((i % 3 == 1) ? 1 : 0);
         sum = sum + ((BIT_LENGTH+4)'(win[i]) << sh);
         lt  = 0;
         le  = 0;
         for (int j = 0; j < 9; j++) begin
            if (win[j] <  win[i]) lt = lt + 1;
            if (win[j] <= win[i]) le = le + 1;
         end
         if (lt <= 4 && le >= 5) med = win[i];
      end
      sum  = sum + (BIT_LENGTH+4)'(8);
      filt = mode_q ? BIT_LENGTH'(sum >> 4) : med;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_count  <= '0;
         mode_q      <= 1'b0;
         row_q       <= RW'(LO);
         col_q       <= RW'(LO);
         gen_done    <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         pixel_out_q <= '0;
      end else begin
         if (accept) begin
            load_count <= CW'(int'(load_count) + take_n);
            if (load_count == '0) mode_q <= bus.mode;
         end
         if (state == LOAD) begin
            row_q    <= RW'(LO);
            col_q    <= RW'(LO);
            gen_done <= 1'b0;
         end else if (advance) begin
            pixel_out_q <= filt;
            out_valid_q <= 1'b1;
            out_last_q  <= at_last_pos;
            if (at_last_pos) begin
               gen_done <= 1'b1;
            end else if (col_q == RW'(HI)) begin
               col_q <= RW'(LO);
               row_q <= row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end else if (xfer) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
         if (xfer && out_last_q) load_count <= '0;
      end
   end
endmodule

// File: tb/tb_img_window_filter.sv
// Directed self-checking bench for img_window_filter (default interior build or replicate build).
module tb_img_window_filter;
`ifdef IMG_WINDOW_REPLICATE_EN
   localparam int DIM  = 4;
   localparam int NOUT = 16;
`else
   localparam int DIM  = 20;
   localparam int NOUT = 324;
`endif
   localparam int BL    = 5;
   localparam int PPC   = 3;
   localparam int NPIX  = DIM * DIM;
   localparam int NBEAT = (NPIX + PPC - 1) / PPC;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   img_window_filter_if #(.BIT_LENGTH(BL), .PIX_PER_CYCLE(PPC)) bus ();

   img_window_filter #(.IMG_DIM(DIM), .BIT_LENGTH(BL), .PIX_PER_CYCLE(PPC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [BL-1:0] img  [NPIX];
   logic [BL-1:0] expv [NPIX];
   logic [BL-1:0] got  [NPIX];
   logic          got_last [NPIX];
   int n_got, first_valid_cyc, stall_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fill_const(input logic [BL-1:0] v);
      for (int i = 0; i < NPIX; i++) img[i] = v;
   endtask

   task automatic exp_const(input logic [BL-1:0] v);
      for (int i = 0; i < NPIX; i++) expv[i] = v;
   endtask

   task automatic set_exp(input int r, input int c, input logic [BL-1:0] v);
      expv[(r - 1) * (DIM - 2) + (c - 1)] = v;
   endtask

   task automatic load_frame(input string tag, input logic m_first, input logic m_rest);
      int rdy_err;
      rdy_err = 0;
      for (int b = 0; b < NBEAT; b++) begin
         for (int k = 0; k < PPC; k++) begin
            if (b * PPC + k < NPIX) bus.pixel_in[k*BL +: BL] = img[b * PPC + k];
            else                    bus.pixel_in[k*BL +: BL] = 5'd31;
         end
         bus.mode     = (b == 0) ? m_first : m_rest;
         bus.in_valid = 1'b1;
         if (bus.in_ready !== 1'b1) rdy_err++;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      check({tag, "_in_ready_load"}, rdy_err, 0);
      check({tag, "_busy_filter"}, bus.busy, 1);
      check({tag, "_in_ready_filter"}, bus.in_ready, 0);
      check({tag, "_valid_at_entry"}, bus.out_valid, 0);
   endtask

   task automatic drain(input int pattern, input int max_xfers, input int budget);
      logic pv, pr, pl;
      logic [BL-1:0] pp;
      int cyc;
      pv = 1'b0; pr = 1'b0; pl = 1'b0; pp = '0; cyc = 0;
      n_got = 0; first_valid_cyc = -1; stall_err = 0;
      while (cyc < budget) begin
         bus.out_ready = (pattern == 0) ? 1'b1 : (cyc % 3 == 0);
         if (pv && !pr && !(bus.out_valid === 1'b1 && bus.pixel_out === pp && bus.out_last === pl))
            stall_err++;
         if (bus.out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
         pv = bus.out_valid; pr = bus.out_ready; pp = bus.pixel_out; pl = bus.out_last;
         if (bus.out_valid === 1'b1 && bus.out_ready && n_got < NPIX) begin
            got[n_got]      = bus.pixel_out;
            got_last[n_got] = bus.out_last;
            n_got++;
         end
         @(posedge clk); #1;
         cyc++;
         if (n_got > 0 && got_last[n_got - 1] === 1'b1) break;
         if (n_got >= max_xfers) break;
      end
      check("drain_in_budget", cyc < budget, 1);
   endtask

   task automatic verify(input string tag, input int nexp);
      int bad, badlast;
      bad = 0; badlast = 0;
      for (int i = 0; i < n_got; i++) begin
         if (got[i] !== expv[i]) bad++;
         if (got_last[i] !== (i == nexp - 1)) badlast++;
      end
      check({tag, "_count"}, n_got, nexp);
      check({tag, "_values"}, bad, 0);
      check({tag, "_last"}, badlast, 0);
      check({tag, "_in_ready_after"}, bus.in_ready, 1);
      check({tag, "_busy_after"}, bus.busy, 0);
      check({tag, "_valid_after"}, bus.out_valid, 0);
   endtask

   task automatic gauss_expect();
      exp_const(0);
      set_exp(5, 5, 4);
      set_exp(4, 5, 2); set_exp(6, 5, 2); set_exp(5, 4, 2); set_exp(5, 6, 2);
      set_exp(4, 4, 1); set_exp(4, 6, 1); set_exp(6, 4, 1); set_exp(6, 6, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.mode = 1'b0; bus.pixel_in = '0;
      #12;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_pixel_out", bus.pixel_out, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_busy", bus.busy, 0);
      @(posedge clk); #1;
      reset = 1'b0;

`ifdef IMG_WINDOW_REPLICATE_EN
      for (int i = 0; i < NPIX; i++) img[i] = BL'(i);
      load_frame("rep", 1'b0, 1'b0);
      drain(0, NOUT, 200);
      check("rep_first_valid", first_valid_cyc, 1);
      check("rep_count", n_got, 16);
      check("rep_px00", got[0], 1);
      check("rep_px11", got[5], 5);
      check("rep_px33", got[15], 14);
      check("rep_last", got_last[15], 1);
      check("rep_last_early", got_last[14], 0);
      check("rep_in_ready_after", bus.in_ready, 1);
`else
      // Constant frame, median.
      fill_const(7);
      load_frame("c7", 1'b0, 1'b0);
      drain(0, NOUT, 2000);
      check("c7_first_valid", first_valid_cyc, 1);
      exp_const(7);
      verify("c7", NOUT);

      // Impulse, Gaussian.
      fill_const(0);
      img[5 * DIM + 5] = 5'd16;
      load_frame("g", 1'b1, 1'b1);
      drain(0, NOUT, 2000);
      check("g_first_valid", first_valid_cyc, 1);
      gauss_expect();
      verify("g", NOUT);
      check("g_center", got[76], 4);
      check("g_north", got[58], 2);
      check("g_diag", got[57], 1);

      // Impulse, median.
      load_frame("m", 1'b0, 1'b0);
      drain(0, NOUT, 2000);
      exp_const(0);
      verify("m", NOUT);

      // Impulse, Gaussian latched on beat 0, stalled output.
      load_frame("gs", 1'b1, 1'b0);
      drain(1, NOUT, 4000);
      check("gs_stall_stable", stall_err, 0);
      gauss_expect();
      verify("gs", NOUT);
      check("gs_center", got[76], 4);

      // Reset mid-stream, then a fresh frame.
      fill_const(7);
      load_frame("r", 1'b0, 1'b0);
      drain(0, 100, 2000);
      check("r_partial_count", n_got, 100);
      check("r_valid_before_rst", bus.out_valid, 1);
      reset = 1'b1;
      #1;
      check("r_out_valid", bus.out_valid, 0);
      check("r_in_ready", bus.in_ready, 1);
      check("r_busy", bus.busy, 0);
      check("r_out_last", bus.out_last, 0);
      check("r_pixel_out", bus.pixel_out, 0);
      #2;
      reset = 1'b0;
      @(posedge clk); #1;
      fill_const(3);
      load_frame("c3", 1'b0, 1'b0);
      drain(0, NOUT, 2000);
      exp_const(3);
      verify("c3", NOUT);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
